// File: rtl/fir_seq_mac_if.sv
// fir_seq_mac_if: bundle of the FIR engine's coefficient-write port,
// sample input handshake and result output handshake.
//   master : drives coef_*, in_valid/in_data, out_ready; sees in_ready,
//            out_valid, out_data
//   slave  : the FIR engine side (mirror of master)
interface fir_seq_mac_if #(
   parameter int DW = 16,
   parameter int CW = 16
);
   logic                 coef_we;
   logic [3:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_data;

   modport master (
      output coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_seq_mac.sv
// fir_seq_mac: sequential single-multiplier FIR engine.
// Accepts one signed sample per in handshake, shifts it into a TAPS-deep
// delay line, then runs one multiply-accumulate per cycle into a 32-bit
// accumulator (exact or ETA1 approximate add, chosen by APPROX) and offers
// the result on the out handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fir_seq_mac_if.slave (coef write, in_*, out_* handshakes)
//
// state | meaning
// IDLE  | in_ready high, coefficient writes applied, waiting for a sample
// MAC   | one tap per cycle, k = 0..TAPS-1
// OUT   | result presented, held until out_ready
module fir_seq_mac #(
   parameter int TAPS   = 8,
   parameter int DW     = 16,
   parameter int CW     = 16,
   parameter int APPROX = 1
) (
   input  logic             clk,
   input  logic             rst,
   fir_seq_mac_if.slave     bus
);
   localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t               state;
   logic signed [DW-1:0] x [TAPS];
   logic signed [CW-1:0] c [TAPS];
   logic [31:0]          acc;
   logic [KW-1:0]        k;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [31:0]          out_data_q;
   logic [31:0]          prod;
   logic [31:0]          acc_next;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Upper 12 bits add exactly; the lower 20 bits take a ^ b down to the
   // first position where both operands are 1, and all ones from there down.
   function automatic logic [31:0] eta1(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      logic        hit;
      s[31:20] = a[31:20] + b[31:20];
      hit      = 1'b0;
      for (int i = 19; i >= 0; i--) begin
         if (!hit && a[i] && b[i]) hit = 1'b1;
         s[i] = hit ? 1'b1 : (a[i] ^ b[i]);
      end
      return s;
   endfunction

   // Sign-extend both operands to 32 bits; the low 32 bits of the unsigned
   // product equal the signed product since DW+CW = 32.
   always_comb begin
      prod = {{(32-DW){x[k][DW-1]}}, x[k]} * {{(32-CW){c[k][CW-1]}}, c[k]};
      if (APPROX != 0) acc_next = eta1(acc, prod);
      else             acc_next = acc + prod;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         acc         <= '0;
         k           <= '0;
         for (int j = 0; j < TAPS; j++) begin
            x[j] <= '0;
            c[j] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.coef_we && (32'(bus.coef_addr) < TAPS))
                  c[bus.coef_addr[KW-1:0]] <= bus.coef_data;
               if (bus.in_valid && in_ready_q) begin
                  for (int j = TAPS - 1; j > 0; j--) x[j] <= x[j-1];
                  x[0]       <= bus.in_data;
                  acc        <= '0;
                  k          <= '0;
                  in_ready_q <= 1'b0;
                  state      <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               k   <= k + 1'b1;
               if (k == KW'(TAPS - 1)) begin
                  k     <= '0;
                  state <= OUT;
               end
            end
            OUT: begin
               // First OUT cycle loads the result; afterwards it is held
               // until the consumer takes it.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
